// File: rtl/msrv32_fetch_flush_ctrl.sv
// msrv32_fetch_flush_ctrl
// Fetch-side program counter and flush sequencer for a single-issue RV32
// core. After reset it spends one BOOT cycle presenting a NOP, then fetches
// sequentially. A taken branch/jump/trap redirects the PC and inserts
// FLUSH_CYCLES NOP bubbles before fetching resumes at the (word-aligned)
// target.
//
// Optional build feature:
//   MSRV32_FETCH_PERF_EN  - when defined, flush_count_out counts cycles with
//                           flush_out=1 (saturating). When undefined the port
//                           reads constant zero and no counter is built.
module msrv32_fetch_flush_ctrl #(
    parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        instr_hready_in,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] pc_out,
    output logic        instr_req_out,
    output logic        flush_out,
    output logic        instr_valid_out,
    output logic        misaligned_out,
    output logic [31:0] flush_count_out
);

    // Bubble counter reload: a value of N-1 yields N FLUSH cycles because
    // the cycle with cnt=0 is itself a bubble.
    localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [3:0]  cnt_reg;
    logic [3:0]  cnt_next;
    logic        misaligned_reg;
    logic        misaligned_next;

    logic        redirect_accept;
    logic [31:0] redirect_target;

    // A redirect only takes effect once the core is running; BOOT ignores it.
    assign redirect_accept = redirect_in &&
                             ((state_reg == ST_FETCH) || (state_reg == ST_FLUSH));

    // Redirect targets are forced to a word boundary; the dropped bits only
    // feed the misalignment flag.
    assign redirect_target = {redirect_pc_in[31:2], 2'b00};

    // State, PC, bubble counter and misalignment flag registers.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= BOOT_ADDR;
            cnt_reg        <= 4'd0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            cnt_reg        <= cnt_next;
            misaligned_reg <= misaligned_next;
        end
    end

    // Next-state logic: redirect wins over stall and memory-not-ready.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        cnt_next        = cnt_reg;
        misaligned_next = 1'b0;

        if (redirect_accept) begin
            state_next      = ST_FLUSH;
            pc_next         = redirect_target;
            cnt_next        = CNT_RELOAD;
            misaligned_next = (redirect_pc_in[1:0] != 2'b00);
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    // Sequential advance wraps naturally at 2^32.
                    if (instr_hready_in && !stall_in) begin
                        pc_next = pc_reg + 32'd4;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_reg == 4'd0) begin
                        state_next = ST_FETCH;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_next = ST_BOOT;
                end
            endcase
        end
    end

    // Output decode: reset shows BOOT values even before the first edge.
    always_comb begin
        flush_out       = 1'b1;
        instr_req_out   = 1'b0;
        instr_valid_out = 1'b0;

        if (!ms_riscv32_mp_rst_in) begin
            case (state_reg)
                ST_FETCH: begin
                    // A stall alone never turns the instruction into a NOP;
                    // it only withholds the valid qualifier.
                    instr_req_out   = 1'b1;
                    flush_out       = !instr_hready_in;
                    instr_valid_out = instr_hready_in && !stall_in;
                end
                default: begin
                    flush_out       = 1'b1;
                    instr_req_out   = 1'b0;
                    instr_valid_out = 1'b0;
                end
            endcase
        end
    end

    assign pc_out         = pc_reg;
    assign misaligned_out = misaligned_reg;

`ifdef MSRV32_FETCH_PERF_EN
    logic [31:0] flush_count_reg;

    // Saturating count of bubble/NOP cycles seen outside reset.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            flush_count_reg <= 32'h0;
        end else if (flush_out && (flush_count_reg != 32'hFFFF_FFFF)) begin
            flush_count_reg <= flush_count_reg + 32'd1;
        end
    end

    assign flush_count_out = flush_count_reg;
`else
    assign flush_count_out = 32'h0;
`endif

endmodule

// File: doc/msrv32_fetch_flush_ctrl.md
MSRV32_FETCH_FLUSH_CTRL -- requirements
Module: msrv32_fetch_flush_ctrl

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 1..15, the number of NOP-bubble cycles after a redirect.
REQ-003 SHALL have ms_riscv32_mp_clk_in, input, 1, the single clock (all state updates on rising edge).
REQ-004 SHALL have ms_riscv32_mp_rst_in, input, 1, the reset, synchronous and active-high.
REQ-005 SHALL have instr_hready_in, input, 1, instruction memory has valid data for pc_out this cycle.
REQ-006 SHALL have stall_in, input, 1, downstream pipeline hold request.
REQ-007 SHALL have redirect_in, input, 1, branch/jump/trap taken.
REQ-008 SHALL have redirect_pc_in, input, 32, redirect target.
REQ-009 SHALL have pc_out, output, 32, current fetch address (registered).
REQ-010 SHALL have instr_req_out, output, 1, fetch request to instruction memory.
REQ-011 SHALL have flush_out, output, 1, drives the instruction mux flush (1 = substitute NOP 32'h00000013).
REQ-012 SHALL have instr_valid_out, output, 1, the instruction presented this cycle is architecturally valid.
REQ-013 SHALL have misaligned_out, output, 1, registered one-cycle pulse for a redirect target with bits [1:0] != 0.
REQ-014 SHALL have flush_count_out, output, 32, count of cycles with flush_out=1 (see Configuration).

Function
REQ-015 SHALL implement states BOOT, FETCH and FLUSH, plus a 4-bit bubble counter cnt.
REQ-016 In BOOT: flush_out=1, instr_req_out=0, instr_valid_out=0; next state is always FETCH; redirect_in is ignored.
REQ-017 In FETCH: instr_req_out=1; flush_out = !instr_hready_in; instr_valid_out = instr_hready_in & !stall_in.
REQ-018 In FETCH with instr_hready_in=1, stall_in=0, redirect_in=0: pc_out <= pc_out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-019 In FETCH with stall_in=1 or instr_hready_in=0: pc_out holds, and flush_out is not asserted due to stall alone.
REQ-020 In FETCH or FLUSH with redirect_in=1: pc_out <= {redirect_pc_in[31:2],2'b00}, state <= FLUSH, cnt <= FLUSH_CYCLES-1.
REQ-021 Redirect priority: redirect_in has priority over stall_in and instr_hready_in.
REQ-022 Redirect in the same cycle as the final FLUSH cycle: the bubble count restarts.
REQ-023 Misalignment: misaligned_out <= redirect_in & (redirect_pc_in[1:0] != 0) whenever a redirect is accepted; otherwise 0 next cycle.
REQ-024 In FLUSH: flush_out=1, instr_req_out=0, instr_valid_out=0, pc_out holds.
REQ-025 In FLUSH, if cnt=0: state <= FETCH; otherwise cnt <= cnt-1.
REQ-026 Redirect latency: exactly FLUSH_CYCLES bubble cycles after the redirect cycle, then FETCH at the target.
REQ-027 flush_out, instr_req_out and instr_valid_out SHALL be combinational from state and inputs; all other outputs SHALL be registered.

Reset
REQ-028 With ms_riscv32_mp_rst_in=1 at a clock edge: state <= BOOT, pc_out <= BOOT_ADDR, cnt <= 0, misaligned_out <= 0, flush_count_out <= 0.
REQ-029 Reset SHALL override redirect_in and stall_in in the same cycle, and SHALL abort an in-progress FLUSH.
REQ-030 While reset is held, outputs SHALL show BOOT values: flush_out=1, instr_req_out=0, instr_valid_out=0.

Configuration
REQ-031 Macro MSRV32_FETCH_PERF_EN defined: flush_count_out increments by 1 on every non-reset cycle with flush_out=1, saturating at 32'hFFFF_FFFF.
REQ-032 Macro MSRV32_FETCH_PERF_EN undefined: flush_count_out is constant 32'h0, no counter register is built, and the port is still present.

Verification
REQ-033 Reset released, hready=1, stall=0 -> one BOOT cycle (flush=1), then pc_out 0x0, 0x4, 0x8 on consecutive cycles, instr_valid_out=1.
REQ-034 In FETCH at pc 0x10, stall_in=1 for 3 cycles -> pc_out stays 0x10, flush_out=0, instr_valid_out=0; increments to 0x14 after stall drops.
REQ-035 Redirect to 0x200 with FLUSH_CYCLES=2 -> flush_out=1 for 2 cycles with pc_out=0x200, then FETCH at 0x200, then 0x204.
REQ-036 Redirect to 0x103 together with stall_in=1 -> pc_out=0x100, misaligned_out=1 for exactly one cycle, FLUSH entered.
REQ-037 pc_out=0xFFFF_FFFC, fetch accepted -> pc_out=0x0000_0000; reset asserted mid-FLUSH -> BOOT next cycle with pc_out=BOOT_ADDR.
REQ-038 With MSRV32_FETCH_PERF_EN defined: BOOT cycle plus one redirect (2 bubbles) plus 1 hready=0 cycle -> flush_count_out=4; undefined -> 0.
